// File: rtl/binary_down_counter.sv
// Loadable, cascadable binary down counter with combinational zero and borrow (udf) outputs.
// Define BINARY_DOWN_COUNTER_RELOAD_EN to turn the wrap into an auto-reload from the last loaded value.
module binary_down_counter #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  output logic [BITS-1:0] out,
  output logic            zero,
  output logic            udf
);

  logic [BITS-1:0] cnt;
  logic [BITS-1:0] cnt_next;
  logic [BITS-1:0] wrap_val;
  logic [BITS:0]   b;

  // Ripple borrow: bit i toggles while every lower bit is already zero.
  always_comb begin
    b    = '0;
    b[0] = ena;
    for (int i = 0; i < BITS; i++) begin
      b[i+1] = ~cnt[i] & b[i];
    end
  end

  assign udf  = b[BITS] & ~load & ~rst;
  assign zero = (cnt == '0);
  assign out  = cnt;

`ifdef BINARY_DOWN_COUNTER_RELOAD_EN
  logic [BITS-1:0] reload_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_reg <= '0;
    end else if (load) begin
      reload_reg <= load_val;
    end
  end

  assign wrap_val = reload_reg;
`else
  assign wrap_val = '1;
`endif

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    cnt_next = cnt;
    if (load) begin
      cnt_next = load_val;
    end else if (udf) begin
      cnt_next = wrap_val;
    end else begin
      cnt_next = cnt ^ b[BITS-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_binary_down_counter.sv
// Directed self-checking bench for binary_down_counter: reset, load, count, priority, async reset, cascade.
// Expected wrap values follow BINARY_DOWN_COUNTER_RELOAD_EN when it is defined.
module tb_binary_down_counter;

  logic       clk = 1'b0;
  logic       rst, ena, load;
  logic [3:0] load_val, out;
  logic       zero, udf;

  logic       c_load, lo_ena;
  logic [3:0] lo_val, hi_val, lo_out, hi_out;
  logic       lo_zero, hi_zero, lo_udf, hi_udf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  binary_down_counter #(.BITS(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .load_val(load_val),
    .out(out), .zero(zero), .udf(udf)
  );

  binary_down_counter #(.BITS(4)) lo (
    .clk(clk), .rst(rst), .ena(lo_ena), .load(c_load), .load_val(lo_val),
    .out(lo_out), .zero(lo_zero), .udf(lo_udf)
  );

  binary_down_counter #(.BITS(4)) hi (
    .clk(clk), .rst(rst), .ena(lo_udf), .load(c_load), .load_val(hi_val),
    .out(hi_out), .zero(hi_zero), .udf(hi_udf)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef BINARY_DOWN_COUNTER_RELOAD_EN
  localparam logic [7:0] WRAP_RST  = 8'd0;
  localparam logic [7:0] WRAP_LD5  = 8'd5;
`else
  localparam logic [7:0] WRAP_RST  = 8'd15;
  localparam logic [7:0] WRAP_LD5  = 8'd15;
`endif

  initial begin
    logic [7:0] exp_out [6];
    logic [7:0] exp_udf [6];
    rst = 1'b1; ena = 1'b1; load = 1'b0; load_val = 4'd0;
    c_load = 1'b0; lo_ena = 1'b0; lo_val = 4'd0; hi_val = 4'd0;

    // 1: reset applied before any clock edge, ena held high
    #2;
    check("rst_out", 8'(out), 8'd0);
    check("rst_zero", 8'(zero), 8'd1);
    check("rst_udf", 8'(udf), 8'd0);
    rst = 1'b0;
    #1;
    check("rel_udf", 8'(udf), 8'd1);
    tick();
    check("rel_wrap", 8'(out), WRAP_RST);

    // 2: load 5 then count six times
    ena = 1'b0; load = 1'b1; load_val = 4'd5;
    tick();
    check("ld5_out", 8'(out), 8'd5);
    load = 1'b0; ena = 1'b1;
    exp_out = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, WRAP_LD5};
    exp_udf = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("cnt_udf%0d", i), 8'(udf), exp_udf[i]);
      tick();
      check($sformatf("cnt_out%0d", i), 8'(out), exp_out[i]);
      check($sformatf("cnt_zero%0d", i), 8'(zero), (exp_out[i] == 8'd0) ? 8'd1 : 8'd0);
    end

    // 3: load beats ena, including when the count sits at 0
    ena = 1'b0; load = 1'b1; load_val = 4'd3;
    tick();
    check("ld3_out", 8'(out), 8'd3);
    ena = 1'b1; load_val = 4'd9;
    #1;
    check("ldena_udf", 8'(udf), 8'd0);
    tick();
    check("ldena_out", 8'(out), 8'd9);
    load_val = 4'd0;
    tick();
    check("ld0_out", 8'(out), 8'd0);
    #1;
    check("ld0_udf_masked", 8'(udf), 8'd0);
    load_val = 4'd9;
    tick();
    load = 1'b0; ena = 1'b0;
    repeat (3) tick();
    check("hold_out", 8'(out), 8'd9);
    check("hold_udf", 8'(udf), 8'd0);

    // 4: asynchronous reset between edges
    ena = 1'b0; load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0; ena = 1'b1;
    tick();
    check("pre_rst_out", 8'(out), 8'd6);
    #2;
    rst = 1'b1;
    #1;
    check("async_out", 8'(out), 8'd0);
    check("async_zero", 8'(zero), 8'd1);
    check("async_udf", 8'(udf), 8'd0);
    #1;
    rst = 1'b0;
    #1;
    check("resume_udf", 8'(udf), 8'd1);
    tick();
    check("resume_out", 8'(out), WRAP_RST);
    ena = 1'b0;

`ifdef BINARY_DOWN_COUNTER_RELOAD_EN
    // 6: auto-reload period of 4 after loading 3
    load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0; ena = 1'b1;
    exp_out = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1};
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = exp_out[i % 4 == 3 ? 3 : i % 4];
      #1;
      check($sformatf("rl_udf%0d", i), 8'(udf), (i % 4 == 3) ? 8'd1 : 8'd0);
      tick();
      check($sformatf("rl_out%0d", i), 8'(out), e);
    end
    ena = 1'b0;
`else
    // 5: two stages cascaded into an 8-bit counter, loaded to 0x10
    c_load = 1'b1; lo_val = 4'h0; hi_val = 4'h1;
    tick();
    check("cas_load", {hi_out, lo_out}, 8'h10);
    c_load = 1'b0; lo_ena = 1'b1;
    #1;
    check("cas_udf_10", 8'(hi_udf), 8'd0);
    tick();
    check("cas_0f", {hi_out, lo_out}, 8'h0F);
    tick();
    check("cas_0e", {hi_out, lo_out}, 8'h0E);
    repeat (13) tick();
    check("cas_01", {hi_out, lo_out}, 8'h01);
    check("cas_udf_01", 8'(hi_udf), 8'd0);
    tick();
    check("cas_00", {hi_out, lo_out}, 8'h00);
    check("cas_udf_00", 8'(hi_udf), 8'd1);
    tick();
    check("cas_ff", {hi_out, lo_out}, 8'hFF);
    check("cas_udf_ff", 8'(hi_udf), 8'd0);
    lo_ena = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
